// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and port index constants.
package memory_arbiter_types;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} arbiter_state_t;

  localparam logic ARB_PORT_IMEM = 1'b0;
  localparam logic ARB_PORT_DMEM = 1'b1;

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational winner pick for the memory arbiter.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin ties; otherwise dmem wins ties.
module arbiter_select
  import memory_arbiter_types::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    unique case (req_i)
      2'b01:   winner_o = ARB_PORT_IMEM;
      2'b10:   winner_o = ARB_PORT_DMEM;
      2'b11:   winner_o = ~last_i;
      default: winner_o = ARB_PORT_IMEM;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    winner_o = req_i[ARB_PORT_DMEM] ? ARB_PORT_DMEM : ARB_PORT_IMEM;
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-to-one arbiter sharing one line-wide memory port between icache and dcache.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin ties (default: fixed dmem priority).
module memory_arbiter
  import memory_arbiter_types::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned LINE_SIZE = 256
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [ADDR_SIZE-1:0] imem_addr_i,
  input  logic [LINE_SIZE-1:0] imem_wr_data_i,
  input  logic                 imem_write_i,
  input  logic                 imem_valid_i,
  output logic [LINE_SIZE-1:0] imem_rd_data_o,
  output logic                 imem_ready_o,
  input  logic [ADDR_SIZE-1:0] dmem_addr_i,
  input  logic [LINE_SIZE-1:0] dmem_wr_data_i,
  input  logic                 dmem_write_i,
  input  logic                 dmem_valid_i,
  output logic [LINE_SIZE-1:0] dmem_rd_data_o,
  output logic                 dmem_ready_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LINE_SIZE-1:0] mem_wr_data_o,
  output logic                 mem_write_o,
  output logic                 mem_valid_o,
  input  logic [LINE_SIZE-1:0] mem_rd_data_i,
  input  logic                 mem_ready_i
);

  arbiter_state_t state_q, state_d;
  logic           owner_q, owner_d;
  logic           winner;
  logic           sel_last;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Reset to dmem so imem wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= ARB_PORT_DMEM;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StWait && mem_ready_i) begin
      last_d = owner_q;
    end
  end

  assign sel_last = last_q;
`else
  assign sel_last = ARB_PORT_DMEM;
`endif

  arbiter_select u_select (
    .req_i    ({dmem_valid_i, imem_valid_i}),
    .last_i   (sel_last),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      owner_q <= ARB_PORT_IMEM;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if ((imem_valid_i || dmem_valid_i) && mem_ready_i) begin
          owner_d = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!mem_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Non-owner sees ready=1 while busy so a pending request is held, not advanced.
  always_comb begin
    mem_valid_o    = (state_q == StIssue);
    mem_addr_o     = '0;
    mem_wr_data_o  = '0;
    mem_write_o    = 1'b0;
    imem_ready_o   = mem_ready_i;
    dmem_ready_o   = mem_ready_i;
    imem_rd_data_o = '0;
    dmem_rd_data_o = '0;
    if (state_q != StIdle) begin
      if (owner_q == ARB_PORT_DMEM) begin
        mem_addr_o     = dmem_addr_i;
        mem_wr_data_o  = dmem_wr_data_i;
        mem_write_o    = dmem_write_i;
        dmem_rd_data_o = mem_rd_data_i;
        imem_ready_o   = 1'b1;
      end else begin
        mem_addr_o     = imem_addr_i;
        mem_wr_data_o  = imem_wr_data_i;
        mem_write_o    = imem_write_i;
        imem_rd_data_o = mem_rd_data_i;
        dmem_ready_o   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: cache master models, a memory model and a
// transaction-level reference for grant order, forwarding and handshake timing.
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk_i;
  logic          reset_i;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [LW-1:0] i_wd, d_wd, m_wd, i_rd, d_rd, m_rd;
  logic          i_wr, d_wr, m_wr, i_valid, d_valid, m_valid;
  logic          i_ready, d_ready, m_ready;

  memory_arbiter #(
    .ADDR_SIZE (AW),
    .LINE_SIZE (LW)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .imem_addr_i    (i_addr),
    .imem_wr_data_i (i_wd),
    .imem_write_i   (i_wr),
    .imem_valid_i   (i_valid),
    .imem_rd_data_o (i_rd),
    .imem_ready_o   (i_ready),
    .dmem_addr_i    (d_addr),
    .dmem_wr_data_i (d_wd),
    .dmem_write_i   (d_wr),
    .dmem_valid_i   (d_valid),
    .dmem_rd_data_o (d_rd),
    .dmem_ready_o   (d_ready),
    .mem_addr_o     (m_addr),
    .mem_wr_data_o  (m_wd),
    .mem_write_o    (m_wr),
    .mem_valid_o    (m_valid),
    .mem_rd_data_i  (m_rd),
    .mem_ready_i    (m_ready)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Cache master models: one outstanding request each, optional auto-generated stream.
  bit            ms_act[2], ms_arm[2], ms_drop[2];
  logic [AW-1:0] ms_addr[2];
  logic          ms_wr[2];
  logic [LW-1:0] ms_wd[2];
  int            ms_left[2], ms_gap[2];
  bit            ms_randgap;

  // Memory model.
  bit            mem_busy, mem_hold, mem_fixed;
  int            mem_cnt;
  int unsigned   lat_lo, lat_hi;
  logic [LW-1:0] mem_resp, fixed_resp;

  // Reference: transaction in flight, expected owner and forwarded fields.
  bit            in_txn, accepted, grant_next, grant_win, last_m;
  logic [AW-1:0] g_addr, e_addr;
  logic          g_wr, e_wr;
  logic [LW-1:0] g_wd, e_wd, last_rdata;
  int            n_done;
  int            grants[$];
  bit            obs_rdy[2];
  bit            obs_mv, obs_mr;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Winner by rule: a lone requester wins; ties by build configuration.
  function automatic bit pick(input bit ri, input bit rd, input bit last);
    if (ri && !rd) return 1'b0;
    if (rd && !ri) return 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    return !last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic new_req(input int p, input logic [AW-1:0] a, input logic w,
                         input logic [LW-1:0] wd);
    ms_act[p]  = 1'b1;
    ms_arm[p]  = 1'b0;
    ms_drop[p] = 1'b0;
    ms_addr[p] = a;
    ms_wr[p]   = w;
    ms_wd[p]   = wd;
  endtask

  task automatic drive_pins();
    i_valid = ms_act[0];
    i_addr  = ms_act[0] ? ms_addr[0] : $urandom();
    i_wr    = ms_act[0] ? ms_wr[0] : ($urandom_range(0, 1) == 1);
    i_wd    = ms_act[0] ? ms_wd[0] : rand_line();
    d_valid = ms_act[1];
    d_addr  = ms_act[1] ? ms_addr[1] : $urandom();
    d_wr    = ms_act[1] ? ms_wr[1] : ($urandom_range(0, 1) == 1);
    d_wd    = ms_act[1] ? ms_wd[1] : rand_line();
  endtask

  // Called just after each rising edge with what was observed in the cycle that ended.
  task automatic drive_update();
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        m_ready  = 1'b1;
        m_rd     = mem_resp;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
        m_rd = rand_line();
      end
    end else if (obs_mv && obs_mr) begin
      m_ready  = 1'b0;
      mem_busy = 1'b1;
      mem_cnt  = int'($urandom_range(lat_hi, lat_lo)) - 1;
      mem_resp = mem_fixed ? fixed_resp : rand_line();
      m_rd     = rand_line();
    end else begin
      m_ready = !mem_hold;
      m_rd    = rand_line();
    end
    for (int p = 0; p < 2; p++) begin
      if (ms_act[p]) begin
        if (ms_drop[p] && obs_rdy[p]) begin
          ms_act[p] = 1'b0;
          ms_gap[p] = ms_randgap ? int'($urandom_range(0, 2)) : 0;
        end else if (ms_arm[p] && !obs_rdy[p]) begin
          ms_drop[p] = 1'b1;
        end else if (obs_rdy[p]) begin
          ms_arm[p] = 1'b1;
        end
      end
      if (!ms_act[p] && ms_left[p] > 0) begin
        if (ms_gap[p] > 0) begin
          ms_gap[p]--;
        end else begin
          new_req(p, $urandom() & 32'hFFFF_FFE0, ($urandom_range(0, 1) == 1), rand_line());
          ms_left[p]--;
        end
      end
    end
    drive_pins();
  endtask

  // Called at the falling edge: compares DUT outputs with the reference for this cycle.
  task automatic check_cycle();
    bit free;
    free = !in_txn && !grant_next;
    if (grant_next) begin
      in_txn   = 1'b1;
      accepted = 1'b0;
      e_addr   = g_addr;
      e_wr     = g_wr;
      e_wd     = g_wd;
      grants.push_back(int'(grant_win));
    end
    chk1("mem_valid", m_valid, in_txn && !accepted);
    if (in_txn) begin
      chkw("fwd_addr", LW'(m_addr), LW'(e_addr));
      chk1("fwd_write", m_wr, e_wr);
      chkw("fwd_wdata", m_wd, e_wd);
      chk1("owner_ready", grant_win ? d_ready : i_ready, m_ready);
      chkw("owner_rdata", grant_win ? d_rd : i_rd, m_rd);
      chk1("other_ready", grant_win ? i_ready : d_ready, 1'b1);
      chkw("other_rdata", grant_win ? i_rd : d_rd, '0);
      if (!accepted) begin
        if (!m_ready) accepted = 1'b1;
      end else if (m_ready) begin
        last_rdata = grant_win ? d_rd : i_rd;
        chkw("done_rdata", last_rdata, mem_resp);
        last_m = grant_win;
        in_txn = 1'b0;
        n_done++;
      end
    end else begin
      chkw("idle_addr", LW'(m_addr), '0);
      chk1("idle_write", m_wr, 1'b0);
      chkw("idle_wdata", m_wd, '0);
      chk1("idle_iready", i_ready, m_ready);
      chk1("idle_dready", d_ready, m_ready);
    end
    grant_next = free && (i_valid || d_valid) && m_ready;
    if (grant_next) begin
      grant_win = pick(i_valid, d_valid, last_m);
      g_addr    = ms_addr[grant_win];
      g_wr      = ms_wr[grant_win];
      g_wd      = ms_wd[grant_win];
    end
    obs_rdy[0] = i_ready;
    obs_rdy[1] = d_ready;
    obs_mv     = m_valid;
    obs_mr     = m_ready;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    drive_update();
    @(negedge clk_i);
    check_cycle();
  endtask

  task automatic run_until(input int target, input int budget);
    int cyc = 0;
    while (n_done < target && cyc < budget) begin
      step();
      cyc++;
    end
    chkw("txn_count", LW'(n_done), LW'(target));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      ms_act[p]  = 1'b0;
      ms_left[p] = 0;
      ms_gap[p]  = 0;
      obs_rdy[p] = 1'b1;
    end
    mem_busy   = 1'b0;
    mem_hold   = 1'b0;
    in_txn     = 1'b0;
    accepted   = 1'b0;
    grant_next = 1'b0;
    last_m     = 1'b1;
    m_ready    = 1'b1;
    m_rd       = rand_line();
    drive_pins();
    #1;
    chk1("rst_mem_valid", m_valid, 1'b0);
    chkw("rst_mem_addr", LW'(m_addr), '0);
    chk1("rst_mem_write", m_wr, 1'b0);
    chkw("rst_mem_wdata", m_wd, '0);
    chkw("rst_i_rdata", i_rd, '0);
    chkw("rst_d_rdata", d_rd, '0);
    chk1("rst_i_ready", i_ready, 1'b1);
    chk1("rst_d_ready", d_ready, 1'b1);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    obs_mv  = 1'b0;
    obs_mr  = 1'b1;
  endtask

  initial begin
    logic [LW-1:0] a5;
    logic [LW-1:0] wb;
    int            base;
    a5         = {32{8'hA5}};
    wb         = {8{32'h1234_5678}};
    fixed_resp = a5;
    ms_randgap = 1'b0;
    mem_fixed  = 1'b0;
    lat_lo     = 4;
    lat_hi     = 4;
    n_done     = 0;
    do_reset();

    // Single fill from imem with a fixed A5 line from memory.
    mem_fixed = 1'b1;
    new_req(0, 32'h0000_1000, 1'b0, rand_line());
    run_until(1, 40);
    chkw("fill_rdata", last_rdata, a5);
    chkw("fill_owner", LW'(grants[0]), LW'(0));
    mem_fixed = 1'b0;

    // Simultaneous requests straight after reset.
    do_reset();
    base = grants.size();
    new_req(0, 32'h0000_3000, 1'b0, rand_line());
    new_req(1, 32'h0000_3100, 1'b0, rand_line());
    run_until(n_done + 2, 60);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    chkw("tie_first", LW'(grants[base]), LW'(0));
    chkw("tie_second", LW'(grants[base + 1]), LW'(1));
`else
    chkw("tie_first", LW'(grants[base]), LW'(1));
    chkw("tie_second", LW'(grants[base + 1]), LW'(0));
`endif

    // Writeback from dmem; forwarding is checked every cycle.
    base = grants.size();
    new_req(1, 32'h0000_2FE0, 1'b1, wb);
    run_until(n_done + 1, 40);
    chkw("wb_owner", LW'(grants[base]), LW'(1));

    // Fairness: both ports request back to back.
    base = grants.size();
    lat_lo     = 1;
    lat_hi     = 3;
    ms_left[0] = 3;
    ms_left[1] = 6;
    run_until(n_done + 9, 200);
    for (int k = 0; k < 6; k++) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      chkw("fair_grant", LW'(grants[base + k]), LW'(k % 2));
`else
      chkw("fair_grant", LW'(grants[base + k]), LW'(1));
`endif
    end

    // Memory not ready while idle: no grant until ready returns.
    mem_hold = 1'b1;
    step();
    new_req(1, 32'h0000_6040, 1'b0, rand_line());
    repeat (3) step();
    chk1("nrdy_dready", d_ready, 1'b0);
    chk1("nrdy_valid", m_valid, 1'b0);
    mem_hold = 1'b0;
    run_until(n_done + 1, 40);

    // Randomized traffic from both ports.
    lat_lo     = 1;
    lat_hi     = 5;
    ms_randgap = 1'b1;
    ms_left[0] = 12;
    ms_left[1] = 12;
    run_until(n_done + 24, 3000);
    ms_randgap = 1'b0;

    // Asynchronous reset while waiting on memory.
    lat_lo = 6;
    lat_hi = 6;
    new_req(0, 32'h0000_4000, 1'b0, rand_line());
    for (int c = 0; c < 40 && !(in_txn && accepted); c++) step();
    step();
    @(posedge clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    chk1("rst_wait_valid", m_valid, 1'b0);
    chkw("rst_wait_addr", LW'(m_addr), '0);
    chkw("rst_wait_rdata", i_rd, '0);
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    base = grants.size();
    new_req(0, 32'h0000_5000, 1'b0, rand_line());
    run_until(n_done + 1, 40);
    chkw("post_rst_owner", LW'(grants[base]), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
